// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALT control, branches and an optional return-address stack.
// The return stack exists only when PC_SEQ_CALL_STACK_EN is defined; otherwise CALL acts as JMP and RET as SEQ.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [7:0] target,
  input  logic       zero,
  input  logic       hlt_req,
  input  logic       resume,
  output logic [7:0] pc,
  output logic       halted,
  output logic [2:0] sp,
  output logic       stk_ovf,
  output logic       stk_unf
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       halted_q, halted_d;
  logic [7:0] pc_inc;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam int         IDX_W   = $clog2(STACK_DEPTH);
  localparam logic [2:0] DEPTH_L = 3'(STACK_DEPTH);

  logic [2:0]       sp_q, sp_d;
  logic             stk_ovf_q, stk_ovf_d;
  logic             stk_unf_q, stk_unf_d;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [7:0]       stack_q [STACK_DEPTH];

  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - 3'd1);
`endif

  always_comb begin
    pc_inc  = pc_q + 8'd1;
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_SEQ_CALL_STACK_EN
    sp_d      = sp_q;
    stk_ovf_d = stk_ovf_q;
    stk_unf_d = stk_unf_q;
    push_en   = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (hlt_req) begin
          state_d = HALT;
        end else begin
          case (op)
            OP_JMP: pc_d = target;
            OP_BZ:  pc_d = zero ? target : pc_inc;
            OP_BNZ: pc_d = zero ? pc_inc : target;
            OP_CALL: begin
              pc_d = target;
`ifdef PC_SEQ_CALL_STACK_EN
              // A full stack still takes the jump but drops the return address.
              if (sp_q == DEPTH_L) begin
                stk_ovf_d = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + 3'd1;
              end
`endif
            end
            OP_RET: begin
`ifdef PC_SEQ_CALL_STACK_EN
              if (sp_q == 3'd0) begin
                pc_d      = pc_inc;
                stk_unf_d = 1'b1;
              end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_q - 3'd1;
              end
`else
              pc_d = pc_inc;
`endif
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= 8'h00;
      halted_q  <= 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
      sp_q      <= 3'd0;
      stk_ovf_q <= 1'b0;
      stk_unf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
`ifdef PC_SEQ_CALL_STACK_EN
      sp_q      <= sp_d;
      stk_ovf_q <= stk_ovf_d;
      stk_unf_q <= stk_unf_d;
`endif
    end
  end

`ifdef PC_SEQ_CALL_STACK_EN
  // Entries are never cleared; sp alone decides which ones are live.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign sp      = sp_q;
  assign stk_ovf = stk_ovf_q;
  assign stk_unf = stk_unf_q;
`else
  assign sp      = 3'd0;
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  assign pc     = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow whether PC_SEQ_CALL_STACK_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BZ   = 3'b010;
  localparam logic [2:0] BNZ  = 3'b011;
  localparam logic [2:0] CALL = 3'b100;
  localparam logic [2:0] RET  = 3'b101;
  localparam logic [2:0] RSV  = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [7:0] target;
  logic       zero;
  logic       hlt_req;
  logic       resume;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] sp;
  logic       stk_ovf;
  logic       stk_unf;

  int n_asserts = 0;
  int n_fail    = 0;

  pc_sequencer #(.STACK_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .target  (target),
    .zero    (zero),
    .hlt_req (hlt_req),
    .resume  (resume),
    .pc      (pc),
    .halted  (halted),
    .sp      (sp),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Apply one set of inputs across one rising edge, then settle 1ns past it.
  task automatic step(input logic [2:0] o, input logic [7:0] t, input logic z,
                      input logic h, input logic r);
    op = o; target = t; zero = z; hlt_req = h; resume = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sel8(input logic [7:0] with_stk, input logic [7:0] no_stk);
    return STK_EN ? with_stk : no_stk;
  endfunction

  function automatic logic [2:0] sel3(input logic [2:0] with_stk);
    return STK_EN ? with_stk : 3'd0;
  endfunction

  logic [7:0] call_tgt [5];
  logic [7:0] ret_exp  [5];

  initial begin
    reset = 1'b1; op = SEQ; target = 8'h00; zero = 1'b0; hlt_req = 1'b0; resume = 1'b0;
    #2;
    check("reset_pc", pc, 8'h00);
    check("reset_halted", halted, 1'b0);
    check("reset_sp", sp, 3'd0);
    check("reset_flags", {stk_ovf, stk_unf}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    check("post_release_pc", pc, 8'h00);

    for (int i = 1; i <= 3; i++) begin
      step(SEQ, 8'h00, 1'b0, 1'b0, 1'b0);
      check($sformatf("seq_%0d", i), pc, 8'(i));
    end

    step(JMP, 8'hFE, 1'b0, 1'b0, 1'b0);
    check("jmp_fe", pc, 8'hFE);
    step(SEQ, 8'h00, 1'b0, 1'b0, 1'b0);
    check("seq_ff", pc, 8'hFF);
    step(SEQ, 8'h00, 1'b0, 1'b0, 1'b0);
    check("seq_wrap", pc, 8'h00);
    step(BZ, 8'h40, 1'b0, 1'b0, 1'b0);
    check("bz_not_taken", pc, 8'h01);
    step(BZ, 8'h40, 1'b1, 1'b0, 1'b0);
    check("bz_taken", pc, 8'h40);
    step(BNZ, 8'h50, 1'b1, 1'b0, 1'b0);
    check("bnz_not_taken", pc, 8'h41);
    step(BNZ, 8'h50, 1'b0, 1'b0, 1'b0);
    check("bnz_taken", pc, 8'h50);
    step(RSV, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("reserved_as_seq", pc, 8'h51);
    step(SEQ, 8'h00, 1'b0, 1'b0, 1'b1);
    check("resume_ignored_in_run", {halted, pc}, {1'b0, 8'h52});

    // Nested call / return
    step(JMP, 8'h10, 1'b0, 1'b0, 1'b0);
    step(CALL, 8'h80, 1'b0, 1'b0, 1'b0);
    check("call1_pc", pc, 8'h80);
    check("call1_sp", sp, sel3(3'd1));
    step(CALL, 8'hA0, 1'b0, 1'b0, 1'b0);
    check("call2_pc", pc, 8'hA0);
    check("call2_sp", sp, sel3(3'd2));
    step(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ret1_pc", pc, sel8(8'h81, 8'hA1));
    check("ret1_sp", sp, sel3(3'd1));
    step(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ret2_pc", pc, sel8(8'h11, 8'hA2));
    check("ret2_sp", sp, sel3(3'd0));

    // CALL from 0xFF returns to 0x00
    step(JMP, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(CALL, 8'h90, 1'b0, 1'b0, 1'b0);
    check("call_at_ff_pc", pc, 8'h90);
    step(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ret_wrap_pc", pc, sel8(8'h00, 8'h91));

    // Overflow and underflow with a depth-4 stack
    call_tgt[0] = 8'h40; call_tgt[1] = 8'h50; call_tgt[2] = 8'h60;
    call_tgt[3] = 8'h70; call_tgt[4] = 8'h7F;
    ret_exp[0] = sel8(8'h61, 8'h80); ret_exp[1] = sel8(8'h51, 8'h81);
    ret_exp[2] = sel8(8'h41, 8'h82); ret_exp[3] = sel8(8'h31, 8'h83);
    ret_exp[4] = sel8(8'h32, 8'h84);
    step(JMP, 8'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(CALL, call_tgt[i], 1'b0, 1'b0, 1'b0);
      check($sformatf("ovf_call%0d_pc", i), pc, call_tgt[i]);
      check($sformatf("ovf_call%0d_sp", i), sp, sel3(3'(i < 4 ? i + 1 : 4)));
      check($sformatf("ovf_call%0d_flag", i), stk_ovf, STK_EN && (i == 4));
    end
    for (int i = 0; i < 5; i++) begin
      step(RET, 8'hEE, 1'b0, 1'b0, 1'b0);
      check($sformatf("unf_ret%0d_pc", i), pc, ret_exp[i]);
      check($sformatf("unf_ret%0d_sp", i), sp, sel3(3'(i < 4 ? 3 - i : 0)));
      check($sformatf("unf_ret%0d_flag", i), stk_unf, STK_EN && (i == 4));
    end
    check("ovf_sticky", stk_ovf, STK_EN);

    // Halt has priority over the op and holds everything until resume
    step(JMP, 8'h20, 1'b0, 1'b0, 1'b0);
    step(JMP, 8'h55, 1'b0, 1'b1, 1'b0);
    check("halt_enter", {halted, pc}, {1'b1, 8'h20});
    for (int i = 0; i < 5; i++) begin
      step(3'(i), 8'(8'h60 + i), i[0], i[1], 1'b0);
      check($sformatf("halt_hold%0d", i), {halted, pc}, {1'b1, 8'h20});
    end
    step(JMP, 8'h77, 1'b0, 1'b1, 1'b1);
    check("resume", {halted, pc}, {1'b0, 8'h21});

    // Async reset while halted with two return addresses live
    step(CALL, 8'h60, 1'b0, 1'b0, 1'b0);
    step(CALL, 8'h70, 1'b0, 1'b0, 1'b0);
    step(SEQ, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pre_reset_state", {halted, sp, pc}, {1'b1, sel3(3'd2), 8'h70});
    check("pre_reset_flags", {stk_ovf, stk_unf}, {STK_EN, STK_EN});
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_pc", pc, 8'h00);
    check("async_reset_state", {halted, sp, stk_ovf, stk_unf}, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    step(SEQ, 8'h00, 1'b0, 1'b0, 1'b0);
    check("after_reset_seq", pc, 8'h01);
    step(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    check("after_reset_ret_empty", {sp, pc}, {3'd0, 8'h02});
    check("after_reset_unf", stk_unf, STK_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
